// File: rtl/mannix_arb_pkg.sv
// Shared types and constants for the mannix read-client arbiter.
package mannix_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Canonical client slots of the accelerator read farm
    localparam int unsigned CL_FCC     = 0;
    localparam int unsigned CL_ACTIV   = 1;
    localparam int unsigned CL_POOL    = 2;
    localparam int unsigned CL_CNN_PIC = 3;
    localparam int unsigned CL_CNN_WGT = 4;

    // Width of a client index; never below one bit
    function automatic int unsigned cl_idx_width(input int unsigned num_clients);
        return (num_clients > 1) ? $clog2(num_clients) : 1;
    endfunction

endpackage

// File: rtl/mannix_tag_fifo.sv
// Synchronous FIFO of client indices that tracks in-flight read requests in issue order.
module mannix_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    // Storage write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/mannix_client_arbiter.sv
// N-client read-request arbiter onto a single DDR read port, with in-order response routing.
// Optional build macro MANNIX_ARB_AGING_EN adds per-client wait counters that force a grant
// once a client has waited AGE_LIMIT cycles.
module mannix_client_arbiter
    import mannix_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS     = 5,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned AGE_LIMIT       = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_mode,
    input  logic [$clog2(NUM_CLIENTS)-1:0]      cfg_prio_top,
    input  logic [NUM_CLIENTS-1:0]              cl_req_valid,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   cl_req_addr,
    output logic [NUM_CLIENTS-1:0]              cl_req_ready,
    output logic [NUM_CLIENTS-1:0]              cl_rsp_valid,
    output logic [DATA_WIDTH-1:0]               cl_rsp_data,
    output logic                                ddr_req_valid,
    output logic [ADDR_WIDTH-1:0]               ddr_req_addr,
    input  logic                                ddr_req_ready,
    input  logic                                ddr_rsp_valid,
    input  logic [DATA_WIDTH-1:0]               ddr_rsp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_cnt,
    output logic                                busy,
    output logic                                err_unexp_rsp
);

    localparam int unsigned IdxW = cl_idx_width(NUM_CLIENTS);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IdxW-1:0]        fifo_head;
    logic                   load_ok;
    logic                   grant;
    logic                   pop;
    logic                   win_found;
    logic [IdxW-1:0]        win_idx;
    logic [NUM_CLIENTS-1:0] win_oh;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [NUM_CLIENTS-1:0] head_oh;
    logic [IdxW-1:0]        rr_ptr_q;

    logic                   req_valid_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [NUM_CLIENTS-1:0] rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic                   err_q;

    // The output register may take a new request when it is empty or draining this cycle,
    // and only while a tag slot is free.
    assign load_ok = (!req_valid_q || ddr_req_ready) && !fifo_full;
    assign grant   = load_ok && win_found && !rst;
    assign pop     = ddr_rsp_valid && !fifo_empty;

`ifdef MANNIX_ARB_AGING_EN
    localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);

    logic [AgeW-1:0] age_q [NUM_CLIENTS];
    logic            age_win_found;
    logic [IdxW-1:0] age_win_idx;

    // Wait counters: count while refused, clear on grant, saturate at the limit
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (rst) begin
                age_q[j] <= '0;
            end else if (cl_req_ready[j]) begin
                age_q[j] <= '0;
            end else if (cl_req_valid[j] && (age_q[j] != AgeW'(AGE_LIMIT))) begin
                age_q[j] <= age_q[j] + AgeW'(1);
            end
        end
    end

    // Lowest-index aged requester
    always_comb begin
        age_win_found = 1'b0;
        age_win_idx   = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (!age_win_found && cl_req_valid[j] && (age_q[j] == AgeW'(AGE_LIMIT))) begin
                age_win_found = 1'b1;
                age_win_idx   = IdxW'(j);
            end
        end
    end
`else
    logic unused_age_limit;
    assign unused_age_limit = ^AGE_LIMIT;
`endif

    // Winner search: cyclic scan from the priority top (fixed) or the pointer (round robin)
    always_comb begin
        int unsigned start;
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        start     = (arb_mode_e'(cfg_mode) == ARB_RR) ? 32'(rr_ptr_q) : 32'(cfg_prio_top);
        // Out-of-range start values fold back into the client range
        if (start >= NUM_CLIENTS) begin
            start = start - NUM_CLIENTS;
        end
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            idx = start + i;
            if (idx >= NUM_CLIENTS) begin
                idx = idx - NUM_CLIENTS;
            end
            if (!win_found && cl_req_valid[IdxW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(idx);
            end
        end
`ifdef MANNIX_ARB_AGING_EN
        if (age_win_found) begin
            win_found = 1'b1;
            win_idx   = age_win_idx;
        end
`endif
    end

    // Decode winner to one-hot and select its address slice
    always_comb begin
        win_oh   = '0;
        win_addr = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (win_idx == IdxW'(j)) begin
                win_oh[j] = 1'b1;
                win_addr  = cl_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Decode FIFO head tag to the response strobe
    always_comb begin
        head_oh = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (fifo_head == IdxW'(j)) begin
                head_oh[j] = 1'b1;
            end
        end
    end

    assign cl_req_ready = grant ? win_oh : '0;

    // Downstream request register: load on grant, hold until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (grant) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= win_addr;
        end else if (ddr_req_ready) begin
            req_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer advances past each winner while in round-robin mode
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (grant && (arb_mode_e'(cfg_mode) == ARB_RR)) begin
            if (win_idx == IdxW'(NUM_CLIENTS - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= win_idx + IdxW'(1);
            end
        end
    end

    // Response routing and sticky unexpected-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (pop) begin
                rsp_valid_q <= head_oh;
                rsp_data_q  <= ddr_rsp_data;
            end
            if (ddr_rsp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    mannix_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IdxW)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (win_idx),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_cnt)
    );

    assign ddr_req_valid = req_valid_q;
    assign ddr_req_addr  = req_addr_q;
    assign cl_rsp_valid  = rsp_valid_q;
    assign cl_rsp_data   = rsp_data_q;
    assign err_unexp_rsp = err_q;
    assign busy          = (outstanding_cnt != '0) || req_valid_q;

endmodule

// File: doc/mannix_client_arbiter.md
Name: mannix_client_arbiter

Overview:
- Parametrised N-client read-request arbiter that funnels accelerator read clients (fcc, active, pool, cnn pic/wgt) onto a single DDR read port.
- Successor to the fixed five-client read arbitration in the mem farm. Adds a client count set by parameter, fixed-priority or round-robin mode, tracking of outstanding requests, and in-order routing of responses back to the requesting client.

Parameters:
- NUM_CLIENTS, 5, number of read clients (≥2)
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, response data width
- MAX_OUTSTANDING, 8, depth of the in-flight tag FIFO (power of 2)
- AGE_LIMIT, 64, wait cycles before aging promotion (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_mode  in  1  0 = fixed priority, 1 = round robin
- cfg_prio_top  in  $clog2(NUM_CLIENTS)  highest-priority client index in fixed mode
- cl_req_valid  in  NUM_CLIENTS  per-client request valid
- cl_req_addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client address; client i occupies slice i
- cl_req_ready  out  NUM_CLIENTS  per-client accept; one-hot or zero
- cl_rsp_valid  out  NUM_CLIENTS  per-client response strobe; one-hot or zero
- cl_rsp_data  out  DATA_WIDTH  response data, broadcast to all clients
- ddr_req_valid  out  1  downstream request valid
- ddr_req_addr  out  ADDR_WIDTH  downstream address
- ddr_req_ready  in  1  downstream accept
- ddr_rsp_valid  in  1  downstream response valid; in order, no backpressure
- ddr_rsp_data  in  DATA_WIDTH  downstream response data
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING)+1  tags currently in flight
- busy  out  1  outstanding_cnt != 0 or ddr_req_valid
- err_unexp_rsp  out  1  sticky: a response arrived while the tag FIFO was empty

Behaviour:
- Reset: all outputs 0, round-robin pointer 0, tag FIFO empty, error flag cleared.
- A reset during operation discards in-flight tags and drops the output register contents. Responses arriving after reset set err_unexp_rsp.
- load_ok = (!ddr_req_valid || ddr_req_ready) && (outstanding_cnt < MAX_OUTSTANDING).
- When load_ok is high, the winner among cl_req_valid gets cl_req_ready[winner] = 1 combinationally. Its address is registered into ddr_req_addr, ddr_req_valid is set next cycle, and the winner index is pushed into the tag FIFO in the same cycle.
- Request latency: client handshake in cycle N → ddr_req_valid in N+1.
- Back-to-back loads are allowed whenever ddr_req_ready is held high.
- ddr_req_valid/ddr_req_addr stay stable until ddr_req_ready. The valid flag clears when ready is seen and no new load occurs.
- Fixed mode: priority descends cyclically from cfg_prio_top (top, top+1, … wrapping at NUM_CLIENTS).
- Round-robin mode: search starts at the pointer. On each grant the pointer becomes winner+1, wrapping to 0.
- A cfg_mode change takes effect on the next arbitration; no flush is performed.
- outstanding_cnt counts pushes not yet matched by a response. A push and a pop in the same cycle leave it unchanged.
- Response path: on ddr_rsp_valid, pop the FIFO head tag. Next cycle, assert cl_rsp_valid[tag] = 1 with cl_rsp_data = the registered ddr_rsp_data (1-cycle latency).
- ddr_rsp_valid with an empty FIFO: the response is dropped, err_unexp_rsp is set, and no cl_rsp_valid is asserted.
- A response may pop in the same cycle its tag is pushed only if the FIFO already held an entry. Order is strict FIFO.

Optional Feature:
- MANNIX_ARB_AGING_EN defined: each client has a wait counter that increments while valid && !ready and clears on grant. A client whose counter reaches AGE_LIMIT overrides the mode and wins. Among aged clients, the lowest index wins.
- MANNIX_ARB_AGING_EN undefined: no counters; pure fixed or round-robin arbitration.

Decomposition:
- Package mannix_arb_pkg holds:
  - arb_mode_e (ARB_FIXED = 0, ARB_RR = 1)
  - the client-index width function
  - client index constants (CL_FCC = 0, CL_ACTIV = 1, CL_POOL = 2, CL_CNN_PIC = 3, CL_CNN_WGT = 4)
- One sub-module: mannix_tag_fifo, a synchronous FIFO of client indices with push/pop/full/empty/count outputs.

Test Plan:
- NUM_CLIENTS = 4, fixed mode, cfg_prio_top = 2, clients 0, 1, 3 valid, ddr_req_ready = 1 → grant order 3, 0, 1; addresses appear on ddr_req_addr one cycle after each grant.
- Round robin, all 4 clients continuously valid, ready = 1 → grants 0, 1, 2, 3, 0, …; the pointer wraps correctly.
- MAX_OUTSTANDING = 8, no responses, 10 requests pending → exactly 8 granted, outstanding_cnt = 8, cl_req_ready stays 0. One response (data 0xA5A5A5A5) returns to the first granted client the following cycle, and one new grant follows.
- Requests to client 1 then client 3, responses 0x11 then 0x33 → cl_rsp_valid[1] with 0x11, then cl_rsp_valid[3] with 0x33, each 1 cycle after ddr_rsp_valid.
- ddr_rsp_valid with nothing outstanding → err_unexp_rsp = 1 and stays set until rst; no cl_rsp_valid.
- With MANNIX_ARB_AGING_EN, fixed mode, client 0 top and always valid, client 3 valid, AGE_LIMIT = 64 → client 3 is granted after exactly 64 wait cycles.
